// File: rtl/tx_sequencer_if.sv
// rtl/tx_sequencer_if.sv - command, matrix read and transmitter signals of tx_sequencer
// master is the sequencer side, slave is the surrounding top level.
interface tx_sequencer_if #(parameter int W = 11) ();
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_kind;
   logic         cmd_row;
   logic [1:0]   cmd_col;
   logic         rd_row;
   logic [1:0]   rd_col;
   logic [W-1:0] rd_data;
   logic         tx_start;
   logic [W-1:0] tx_data;
   logic         tx_busy;
   logic         seq_busy;

   modport master (
      input  cmd_valid, cmd_kind, cmd_row, cmd_col, rd_data, tx_busy,
      output cmd_ready, rd_row, rd_col, tx_start, tx_data, seq_busy
   );

   modport slave (
      output cmd_valid, cmd_kind, cmd_row, cmd_col, rd_data, tx_busy,
      input  cmd_ready, rd_row, rd_col, tx_start, tx_data, seq_busy
   );
endinterface

// File: rtl/tx_sequencer.sv
// rtl/tx_sequencer.sv - queued cell/row/column transmit sequencer feeding the UART transmitter
// Optional TX_SEQ_ABORT_EN adds an abort input that flushes the queue and ends the current command.
module tx_sequencer #(
   parameter int W     = 11,
   parameter int DEPTH = 4
) (
   input logic            clk,
   input logic            rst,
`ifdef TX_SEQ_ABORT_EN
   input logic            abort,
`endif
   tx_sequencer_if.master bus
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [1:0] kind;
      logic       row;
      logic [1:0] col;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_IDLE} state_t;

   cmd_t          fifo_q [DEPTH];
   cmd_t          fifo_d [DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d;
   logic [AW:0]   rd_ptr_q, rd_ptr_d;
   state_t        state_q, state_d;
   cmd_t          cur_q, cur_d;
   logic [1:0]    idx_q, idx_d;
   logic          tx_start_q, tx_start_d;
   logic [W-1:0]  tx_data_q, tx_data_d;
   logic          stop_q, stop_d;

   logic          abort_i;
   logic          fifo_empty, fifo_full;
   logic          push, pop;
   cmd_t          head;
   logic          rd_row_c;
   logic [1:0]    rd_col_c;
   logic          last_elem;

`ifdef TX_SEQ_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head       = fifo_q[rd_ptr_q[AW-1:0]];

   // Element address follows the current command; parked at (0,0) while idle.
   always_comb begin
      rd_row_c  = 1'b0;
      rd_col_c  = 2'd0;
      last_elem = 1'b1;
      if (state_q != S_IDLE) begin
         case (cur_q.kind)
            2'd0: begin
               rd_row_c = cur_q.row;
               rd_col_c = cur_q.col;
            end
            2'd1: begin
               rd_row_c  = cur_q.row;
               rd_col_c  = idx_q;
               last_elem = (idx_q == 2'd3);
            end
            2'd2: begin
               rd_row_c  = idx_q[0];
               rd_col_c  = cur_q.col;
               last_elem = (idx_q == 2'd1);
            end
            default: last_elem = 1'b1;
         endcase
      end
   end

   always_comb begin
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      state_d    = state_q;
      cur_d      = cur_q;
      idx_d      = idx_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      stop_d     = stop_q;
      pop        = 1'b0;
      push       = bus.cmd_valid && !fifo_full && !abort_i;

      case (state_q)
         S_IDLE: begin
            stop_d = 1'b0;
            if (!fifo_empty && !abort_i) begin
               pop   = 1'b1;
               cur_d = head;
               idx_d = 2'd0;
               if (head.kind != 2'd3) state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else begin
               tx_data_d  = bus.rd_data;
               tx_start_d = 1'b1;
               state_d    = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            if (abort_i) stop_d = 1'b1;
            if (bus.tx_busy) state_d = S_WAIT_IDLE;
         end
         S_WAIT_IDLE: begin
            if (abort_i) stop_d = 1'b1;
            if (!bus.tx_busy) begin
               if (last_elem || stop_q || abort_i) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (push) begin
         fifo_d[wr_ptr_q[AW-1:0]] = '{kind: bus.cmd_kind, row: bus.cmd_row, col: bus.cmd_col};
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      // Flush: pushes are already blocked, so the write pointer is the new head.
      if (abort_i) rd_ptr_d = wr_ptr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         state_q    <= S_IDLE;
         cur_q      <= '0;
         idx_q      <= 2'd0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         stop_q     <= 1'b0;
      end else begin
         fifo_q     <= fifo_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         state_q    <= state_d;
         cur_q      <= cur_d;
         idx_q      <= idx_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         stop_q     <= stop_d;
      end
   end

   assign bus.cmd_ready = !fifo_full;
   assign bus.rd_row    = rd_row_c;
   assign bus.rd_col    = rd_col_c;
   assign bus.tx_start  = tx_start_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.seq_busy  = !fifo_empty || (state_q != S_IDLE);
endmodule

// File: tb/tb_tx_sequencer.sv
// tb/tb_tx_sequencer.sv - directed bench for tx_sequencer with a 2x4 matrix and a 20-cycle transmitter model
// Abort scenario is compiled in when TX_SEQ_ABORT_EN is defined.
module tb_tx_sequencer;
   localparam int W     = 11;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
`ifdef TX_SEQ_ABORT_EN
   logic abort;
`endif

   tx_sequencer_if #(.W(W)) bus ();

   tx_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef TX_SEQ_ABORT_EN
      .abort (abort),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [W-1:0] mat [2][4];
   assign bus.rd_data = mat[bus.rd_row][bus.rd_col];

   int tx_cnt = 0;
   assign bus.tx_busy = (tx_cnt != 0);

   int           cyc = 0;
   int           start_edge [$];
   logic [W-1:0] start_data [$];

   // Edge counter, start-pulse log and transmitter model (busy 20 cycles per start).
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.tx_start) begin
         start_edge.push_back(cyc + 1);
         start_data.push_back(bus.tx_data);
      end
      if (bus.tx_start && tx_cnt == 0) tx_cnt <= 20;
      else if (tx_cnt != 0)            tx_cnt <= tx_cnt - 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns the number of the accepting edge.
   task automatic push(input logic [1:0] k, input logic r, input logic [1:0] c, output int acc);
      int n;
      acc = -1;
      n   = 0;
      bus.cmd_kind  = k;
      bus.cmd_row   = r;
      bus.cmd_col   = c;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_ready) begin
         check_val("push_timeout", {31'd0, bus.cmd_ready}, 32'd1);
      end else begin
         @(posedge clk);
         @(negedge clk);
         acc = cyc;
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(output int fall);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.seq_busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_val("idle_timeout", {31'd0, bus.seq_busy}, 32'd0);
      fall = cyc;
   endtask

   task automatic wait_starts(input int cnt);
      int n;
      n = 0;
      while (start_edge.size() < cnt && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check_val("starts_timeout", start_edge.size(), cnt);
   endtask

   int acc, acc2, fall, base, n;
   int exp2 [6] = '{1, 2, 3, 4, 3, 1365};
   int gap2 [5] = '{23, 23, 23, 24, 23};
   int exp3 [8] = '{5, 6, 7, 8, 1, 5, 6, 4};

   initial begin
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++)
            mat[r][c] = W'(r * 4 + c + 1);
      bus.cmd_valid = 1'b0;
      bus.cmd_kind  = 2'd0;
      bus.cmd_row   = 1'b0;
      bus.cmd_col   = 2'd0;
`ifdef TX_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      check_val("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      check_val("rst_tx_start",  {31'd0, bus.tx_start}, 32'd0);
      check_val("rst_tx_data",   {21'd0, bus.tx_data}, 32'd0);
      check_val("rst_rd_row",    {31'd0, bus.rd_row}, 32'd0);
      check_val("rst_rd_col",    {30'd0, bus.rd_col}, 32'd0);
      check_val("rst_seq_busy",  {31'd0, bus.seq_busy}, 32'd0);

      // Cell (1,3): one word, start three edges after accept, idle 21 edges after start
      base = start_edge.size();
      push(2'd0, 1'b1, 2'd3, acc);
      check_val("cell_busy_after_accept", {31'd0, bus.seq_busy}, 32'd1);
      wait_idle(fall);
      check_val("cell_count", start_edge.size() - base, 1);
      check_val("cell_data", {21'd0, start_data[base]}, 8);
      check_val("cell_latency", start_edge[base] - acc, 3);
      check_val("cell_idle_after", fall - start_edge[base], 21);

      // Row 0 with column 2 queued; cell (1,2) rewritten before its issue
      base = start_edge.size();
      push(2'd1, 1'b0, 2'd0, acc);
      push(2'd2, 1'b0, 2'd2, acc2);
      wait_starts(base + 5);
      @(negedge clk);
      mat[1][2] = 11'd1365;
      wait_idle(fall);
      mat[1][2] = 11'd7;
      check_val("rowcol_count", start_edge.size() - base, 6);
      check_val("rowcol_latency", start_edge[base] - acc, 3);
      for (int i = 0; i < 6; i++)
         check_val($sformatf("rowcol_data%0d", i), {21'd0, start_data[base + i]}, exp2[i]);
      for (int i = 0; i < 5; i++)
         check_val($sformatf("rowcol_gap%0d", i), start_edge[base + i + 1] - start_edge[base + i], gap2[i]);

      // Fill the queue behind row 1, fifth push stalls, kind 3 sends nothing
      base = start_edge.size();
      push(2'd1, 1'b1, 2'd0, acc);
      wait_starts(base + 1);
      push(2'd0, 1'b0, 2'd0, acc2);
      push(2'd3, 1'b0, 2'd0, acc2);
      push(2'd0, 1'b1, 2'd0, acc2);
      push(2'd0, 1'b1, 2'd1, acc2);
      check_val("full_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
      push(2'd0, 1'b0, 2'd3, acc2);
      check_val("stall_accept_edge", acc2 - start_edge[base + 3], 23);
      wait_idle(fall);
      check_val("full_count", start_edge.size() - base, 8);
      for (int i = 0; i < 8; i++)
         check_val($sformatf("full_data%0d", i), {21'd0, start_data[base + i]}, exp3[i]);

      // Reset while the second word of row 1 is being started
      base = start_edge.size();
      push(2'd1, 1'b1, 2'd0, acc);
      n = 0;
      while (!(bus.tx_start && start_edge.size() == base + 1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val("rst_wait_word2", {31'd0, bus.tx_start}, 32'd1);
      #1 rst = 1'b1;
      #1;
      check_val("midrst_tx_start",  {31'd0, bus.tx_start}, 32'd0);
      check_val("midrst_seq_busy",  {31'd0, bus.seq_busy}, 32'd0);
      check_val("midrst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check_val("midrst_no_more_words", start_edge.size() - base, 1);
      check_val("midrst_idle", {31'd0, bus.seq_busy}, 32'd0);

`ifdef TX_SEQ_ABORT_EN
      // Abort during word 6 of row 1 with two cells queued
      base = start_edge.size();
      push(2'd1, 1'b1, 2'd0, acc);
      push(2'd0, 1'b0, 2'd0, acc2);
      push(2'd0, 1'b0, 2'd1, acc2);
      wait_starts(base + 2);
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_idle(fall);
      repeat (40) @(negedge clk);
      check_val("abort_count", start_edge.size() - base, 2);
      check_val("abort_last_data", {21'd0, start_data[base + 1]}, 6);
      check_val("abort_idle_after", fall - start_edge[base + 1], 21);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/tx_sequencer.md
# tx_sequencer

Command-queued transmit controller between the matrix register file and the UART transmitter. Accepts "send cell / send row / send column" commands into a small FIFO, even while a transfer is in progress. Walks the addressed matrix elements in order and hands each word to the transmitter with a start/busy handshake. Sits where the top level currently decodes transmit actions directly, and replaces that decoding.

## Interface
- `W`, 11, data word width (matches transmitter/matrix cell width)
- `DEPTH`, 4, command FIFO entries (power of two, ≥2)

- `clk` in 1 — system clock, all state on rising edge
- `rst` in 1 — asynchronous, active-high reset
- `cmd_valid` in 1 — command present
- `cmd_ready` out 1 — FIFO can accept; transfer on `cmd_valid && cmd_ready` at rising edge
- `cmd_kind` in 2 — 0 cell, 1 row, 2 column, 3 reserved
- `cmd_row` in 1 — row index (cell/row commands)
- `cmd_col` in 2 — column index (cell/column commands)
- `rd_row` out 1 — matrix read row address
- `rd_col` out 2 — matrix read column address
- `rd_data` in W — matrix read data, combinational from `rd_row`/`rd_col`
- `tx_start` out 1 — one-cycle start pulse to transmitter
- `tx_data` out W — word to send, valid while `tx_start`=1 and held until next start
- `tx_busy` in 1 — transmitter busy
- `seq_busy` out 1 — FIFO non-empty or FSM not IDLE

## Operation
- FIFO: DEPTH entries of {kind,row,col}.
  - `cmd_ready` = !full.
  - A push while full is ignored.
  - Push and pop in the same cycle are both performed.
  - Kind 3 is accepted, then discarded on pop (no transmission, back to IDLE).
- Current command register: kind, row, col, element index `idx` (2 bits).
- Word order:
  - Cell: (row,col).
  - Row: (row,0),(row,1),(row,2),(row,3).
  - Column: (0,col),(1,col).
- `rd_row`/`rd_col` always reflect the current element; they are 0 in IDLE.
- FSM states:
  - IDLE: if FIFO non-empty → pop, latch command, `idx`=0, go to ISSUE (kind 3 → stay IDLE).
  - ISSUE: register `tx_data`←`rd_data`, `tx_start`←1 → WAIT_BUSY.
  - WAIT_BUSY: `tx_start`←0. When `tx_busy`=1 → WAIT_IDLE.
  - WAIT_IDLE: when `tx_busy`=0:
    - If last element → IDLE.
    - Else `idx`++ → ISSUE.
- If `tx_busy` is already 1 when entering ISSUE, the sequencer still issues. The transmitter must not be driven by anything else, so this case arises only from misuse.

## Timing
- Reset values: `cmd_ready`=1, `tx_start`=0, `tx_data`=0, `rd_row`=0, `rd_col`=0, `seq_busy`=0, FIFO empty, FSM IDLE, `idx`=0.
- Command accepted at edge E0 with FSM IDLE and FIFO empty:
  - `seq_busy`=1 after E0.
  - Pop at E1.
  - `tx_start`=1 during cycle E2–E3, exactly one cycle.
- Inter-word gap: `tx_busy` falling edge sampled at edge Ek → ISSUE → `tx_start` high after Ek+1. That is two cycles from `tx_busy`=0 to the next start.
- Back-to-back commands: the next command is popped the cycle after returning to IDLE.
- `rd_data` is sampled only in ISSUE. Matrix writes during a transfer affect words not yet issued.
- Reset asserted mid-transfer:
  - All state clears immediately, including queued commands.
  - `tx_start` drops asynchronously.
  - The transmitter's in-flight frame is not the sequencer's concern.

## Configuration
- `TX_SEQ_ABORT_EN` defined:
  - Adds input `abort` (1 bit).
  - `abort`=1 at an edge flushes the FIFO. A command pushed in the same cycle is dropped.
  - Marks the current command finished: the word in flight completes (FSM waits through WAIT_BUSY/WAIT_IDLE), then goes to IDLE without issuing further elements.
  - `abort` in ISSUE suppresses that word's `tx_start`.
- Not defined: no `abort` port; commands always run to completion.

## Test plan
- Matrix rows {1,2,3,4},{5,6,7,8}, model transmitter busy 20 cycles; command cell (1,3) → single `tx_start` two cycles after accept, `tx_data`=8, `seq_busy` falls after `tx_busy` falls.
- Row 0 command → four pulses with `tx_data` 1,2,3,4, each start exactly two cycles after previous `tx_busy` fall.
- Column 2 command queued behind row 0 → after 1,2,3,4 the output continues 3,7 with no extra idle beyond the pop cycle; modify cell (1,2)=1365 before its ISSUE → second word 1365.
- Push 5 commands while busy with DEPTH=4 → `cmd_ready`=0 after fourth is queued (one popped), fifth stalls until a pop; kind 3 produces no `tx_start`.
- Assert `rst` during row transfer after word 2 → `tx_start`/`seq_busy` 0 immediately, `cmd_ready`=1, no further words after release.
- With `TX_SEQ_ABORT_EN`: abort during word 2 of row 1 with 2 queued → word 6 completes, no 7/8, no queued commands run, `seq_busy`=0 after `tx_busy` falls.
